tx_frame_serializer: RTL and testbench



---
 rtl/tx_frame_serializer.sv | 221 ++++++++++++++++++++++
 tb/tb_tx_frame_serializer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_serializer.sv
// tx_frame_serializer: pops a programmed number of bytes from the transmit
// FIFO, shifts them MSB-first over a bit valid/ready handshake and optionally
// appends the complemented Gen2 CRC-16. All outputs come straight from flops.
module tx_frame_serializer #(
    parameter int RD_LAT = 2,   // cycles from fifo_read pulse to valid fifo_data (1..3)
    parameter int LEN_W  = 6    // width of frame_len
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             crc_en,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_data,
    output logic             fifo_read,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             busy,
    output logic             done,
    output logic             underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_CRC,
        S_DONE
    } state_t;

    // WAIT spans RD_LAT cycles after the pop cycle; data is captured on the last.
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             crc_en_q, crc_en_d;
    logic [15:0]      crc_q, crc_d;
    logic [15:0]      shift_q, shift_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic             fifo_read_q, fifo_read_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic             crc_fb;
    logic [15:0]      crc_next;

    assign fifo_read = fifo_read_q;
    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

    // Handshake and the CRC value after absorbing the bit currently on the line.
    always_comb begin
        accept   = bit_valid_q && bit_ready;
        crc_fb   = crc_q[15] ^ shift_q[15];
        crc_next = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        crc_en_d    = crc_en_q;
        crc_d       = crc_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        underrun_d  = underrun_q;
        busy_d      = busy_q;
        fifo_read_d = 1'b0;
        done_d      = 1'b0;
        bit_valid_d = 1'b0;
        bit_out_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && en) begin
                    byte_cnt_d = frame_len;
                    crc_en_d   = crc_en;
                    crc_d      = 16'hFFFF;
                    underrun_d = 1'b0;
                    busy_d     = 1'b1;
                    if (frame_len != '0) begin
                        // Pop is issued in the first FETCH cycle when data is there.
                        state_d     = S_FETCH;
                        fifo_read_d = !fifo_empty;
                    end else if (crc_en) begin
                        state_d   = S_CRC;
                        shift_d   = ~16'hFFFF;
                        bit_cnt_d = 5'd16;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (fifo_read_q) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_LAST;
                end else if (fifo_empty) begin
                    // Stall without aborting; the flag stays up for the frame.
                    underrun_d = 1'b1;
                end else begin
                    fifo_read_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    shift_d   = {fifo_data, 8'h00};
                    bit_cnt_d = 5'd8;
                    state_d   = S_SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            S_SHIFT: begin
                if (accept) begin
                    shift_d   = {shift_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                    crc_d     = crc_next;
                    if (bit_cnt_q == 5'd1) begin
                        if (byte_cnt_q != '0) begin
                            byte_cnt_d = byte_cnt_q - LEN_W'(1);
                        end
                        if (byte_cnt_q > LEN_W'(1)) begin
                            state_d     = S_FETCH;
                            fifo_read_d = !fifo_empty;
                        end else if (crc_en_q) begin
                            state_d   = S_CRC;
                            shift_d   = ~crc_next;
                            bit_cnt_d = 5'd16;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            S_CRC: begin
                if (accept) begin
                    shift_d   = {shift_q[14:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - 5'd1;
                    if (bit_cnt_q == 5'd1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The line carries the top of the shift register in both bit states,
        // so an unaccepted bit naturally holds.
        if (state_d == S_SHIFT || state_d == S_CRC) begin
            bit_valid_d = 1'b1;
            bit_out_d   = shift_d[15];
        end

        // Disable wins over everything; underrun is kept for software to read.
        if (!en) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            fifo_read_d = 1'b0;
            bit_valid_d = 1'b0;
            bit_out_d   = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            byte_cnt_q  <= '0;
            crc_en_q    <= 1'b0;
            crc_q       <= 16'hFFFF;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            fifo_read_q <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_en_q    <= crc_en_d;
            crc_q       <= crc_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fifo_read_q <= fifo_read_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Bench for tx_frame_serializer: a queue-based FIFO with read latency, a
// bit-capturing encoder model and a byte-wise CRC reference.
module tb_tx_frame_serializer;

    localparam int RL = 2;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] frame_len = '0;
    logic          crc_en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [7:0]    fifo_data = 8'h00;
    logic          fifo_read, bit_out, bit_valid, busy, done, underrun;
    logic          bit_ready = 1'b1;

    tx_frame_serializer #(.RD_LAT(RL), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .start(start),
        .frame_len(frame_len), .crc_en(crc_en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_read(fifo_read), .bit_out(bit_out),
        .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Monitor state
    int   cyc = 0;
    bit   fq[$];
    logic [7:0] fifo_q[$];
    bit   cap[$];
    bit   expq[$];
    int   nreads, ndone, consec_err, hold_err, zero_err;
    int   acc_cyc, first_v, last_acc, done_cyc;
    bit   prev_read, held_pending, held_bit;
    logic [8:0] dl [0:RL];
    int   rmode = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Encoder ready pattern
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: bit_ready = 1'b1;
            1: bit_ready = ~bit_ready;
            default: bit_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // FIFO model with read latency, plus line observation
    always @(negedge clk) begin
        logic [7:0] v;
        for (int i = 0; i < RL; i++) dl[i] = dl[i+1];
        dl[RL] = 9'h000;
        if (start && en && !busy) acc_cyc = cyc + 1;
        if (bit_valid && first_v < 0) first_v = cyc + 1;
        if (fifo_read) begin
            nreads++;
            if (prev_read) consec_err++;
            if (fifo_q.size() > 0) v = fifo_q.pop_front();
            else v = 8'($urandom);
            dl[RL] = {1'b1, v};
        end
        prev_read = fifo_read;
        if (held_pending && (!bit_valid || bit_out != held_bit)) hold_err++;
        held_pending = bit_valid && !bit_ready;
        held_bit     = bit_out;
        if (!bit_valid && bit_out) zero_err++;
        if (bit_valid && bit_ready) begin
            cap.push_back(bit_out);
            last_acc = cyc + 1;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc + 1;
        end
        fifo_data  = dl[0][8] ? dl[0][7:0] : 8'($urandom);
        fifo_empty = (fifo_q.size() == 0);
    end

    task automatic clear_mon();
        cap.delete();
        expq.delete();
        nreads = 0; ndone = 0; consec_err = 0; hold_err = 0; zero_err = 0;
        acc_cyc = -1; first_v = -1; last_acc = -1; done_cyc = -1;
        held_pending = 1'b0;
    endtask

    function automatic logic [15:0] crc16(input logic [7:0] b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) begin
            c = c ^ {b[i], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Expected line content: payload MSB-first, then the complemented CRC.
    task automatic build_exp(input logic [7:0] b[$], input bit c);
        logic [15:0] r;
        foreach (b[i])
            for (int k = 7; k >= 0; k--) expq.push_back(b[i][k]);
        if (c) begin
            r = ~crc16(b);
            for (int k = 15; k >= 0; k--) expq.push_back(r[k]);
        end
    endtask

    function automatic int nmis();
        int m = 0;
        if (cap.size() != expq.size()) return 999;
        foreach (cap[i]) if (cap[i] != expq[i]) m++;
        return m;
    endfunction

    task automatic go(input int len, input bit c);
        @(posedge clk); #1;
        start = 1'b1; frame_len = LW'(len); crc_en = c;
        @(posedge clk); #1;
        start = 1'b0; frame_len = LW'($urandom); crc_en = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (ndone == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("timeout", 32'(n >= 3000), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_bits(input int nb);
        int n = 0;
        while (cap.size() < nb && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk("bits_timeout", 32'(n >= 3000), 0);
    endtask

    task automatic push(input logic [7:0] b[$]);
        foreach (b[i]) fifo_q.push_back(b[i]);
    endtask

    initial begin
        logic [7:0] bq[$];
        int len;
        bit c;
        for (int i = 0; i <= RL; i++) dl[i] = 9'h000;
        clear_mon();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {26'd0, fifo_read, bit_out, bit_valid, busy, done, underrun}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Nine ASCII digits with CRC
        clear_mon(); rmode = 0;
        bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push(bq);
        build_exp(bq, 1'b1);
        go(9, 1'b1);
        chk("digits_busy", 32'(busy), 1);
        wait_done();
        chk("digits_bits", 32'(nmis()), 0);
        chk("digits_crc", 32'(crc16(bq)), 32'h29B1);
        chk("digits_reads", 32'(nreads), 9);
        chk("digits_done", 32'(ndone), 1);
        chk("digits_underrun", 32'(underrun), 0);
        chk("digits_consec", 32'(consec_err), 0);
        chk("digits_first_valid", 32'(first_v - acc_cyc), 32'(RL + 2));
        chk("digits_done_lat", 32'(done_cyc - last_acc), 1);
        chk("digits_busy_end", 32'(busy), 0);

        // Single byte, ready toggling every cycle
        clear_mon(); rmode = 1;
        bq = '{8'hA5};
        push(bq);
        build_exp(bq, 1'b0);
        go(1, 1'b0);
        wait_done();
        chk("a5_bits", 32'(nmis()), 0);
        chk("a5_hold", 32'(hold_err), 0);
        chk("a5_done_lat", 32'(done_cyc - last_acc), 1);
        chk("a5_zero", 32'(zero_err), 0);

        // Empty payload with CRC: sixteen zero bits
        clear_mon(); rmode = 2;
        bq.delete();
        build_exp(bq, 1'b1);
        go(0, 1'b1);
        wait_done();
        chk("len0crc_bits", 32'(nmis()), 0);
        chk("len0crc_reads", 32'(nreads), 0);

        // Empty payload, no CRC
        clear_mon(); rmode = 0;
        go(0, 1'b0);
        wait_done();
        chk("len0_bits", 32'(cap.size()), 0);
        chk("len0_done", 32'(ndone), 1);
        chk("len0_done_lat", 32'((done_cyc - acc_cyc) <= 2 && done_cyc > acc_cyc), 1);

        // Underrun: one byte queued, two more arrive later
        clear_mon(); rmode = 0;
        bq = '{8'h5C, 8'h0F, 8'hE1};
        fifo_q.push_back(bq[0]);
        build_exp(bq, 1'b1);
        go(3, 1'b1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        chk("ur_flag", 32'(underrun), 1);
        chk("ur_stall_valid", 32'(bit_valid), 0);
        chk("ur_stall_busy", 32'(busy), 1);
        repeat (5) @(posedge clk);
        #1;
        fifo_q.push_back(bq[1]);
        fifo_q.push_back(bq[2]);
        wait_done();
        chk("ur_bits", 32'(nmis()), 0);
        chk("ur_sticky", 32'(underrun), 1);
        clear_mon();
        bq = '{8'h96};
        push(bq);
        build_exp(bq, 1'b0);
        go(1, 1'b0);
        @(negedge clk);
        chk("ur_cleared", 32'(underrun), 0);
        wait_done();
        chk("ur_next_bits", 32'(nmis()), 0);

        // Disable mid-byte 2 of 4
        clear_mon(); rmode = 0;
        bq = '{8'h11, 8'h22, 8'h33, 8'h44};
        push(bq);
        go(4, 1'b1);
        wait_bits(12);
        #1;
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 32'(bit_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        repeat (10) @(posedge clk);
        chk("abort_nodone", 32'(ndone), 0);
        #1;
        en = 1'b1;
        fifo_q.delete();
        repeat (4) @(posedge clk);
        clear_mon(); rmode = 2;
        bq.delete();
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
        push(bq);
        build_exp(bq, 1'b1);
        go(len, 1'b1);
        wait_done();
        chk("after_abort_bits", 32'(nmis()), 0);
        chk("after_abort_hold", 32'(hold_err), 0);

        // Reset for one edge in the middle of the CRC
        clear_mon(); rmode = 0;
        bq = '{8'hC3, 8'h3C};
        push(bq);
        go(2, 1'b1);
        wait_bits(19);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midreset_outs", {26'd0, fifo_read, bit_out, bit_valid, busy, done, underrun}, 0);
        repeat (4) @(posedge clk);

        // start while busy is ignored
        clear_mon(); rmode = 2;
        bq = '{8'h7E, 8'h81};
        push(bq);
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'h55);
        build_exp(bq, 1'b0);
        go(2, 1'b0);
        repeat (3) @(posedge clk);
        go(2, 1'b1);
        wait_done();
        repeat (40) @(posedge clk);
        chk("busy_start_done", 32'(ndone), 1);
        chk("busy_start_reads", 32'(nreads), 2);
        chk("busy_start_bits", 32'(nmis()), 0);
        fifo_q.delete();
        repeat (4) @(posedge clk);

        // Random frames
        for (int t = 0; t < 6; t++) begin
            clear_mon(); rmode = $urandom_range(0, 2);
            bq.delete();
            len = $urandom_range(0, 7);
            c = 1'($urandom);
            for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            push(bq);
            build_exp(bq, c);
            go(len, c);
            wait_done();
            chk("rand_bits", 32'(nmis()), 0);
            chk("rand_reads", 32'(nreads), 32'(len));
            chk("rand_hold", 32'(hold_err + consec_err + zero_err), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
